// File: rtl/nc_predict_pkg.sv
// Shared definitions for the nC predictor: component bases, FSM encoding and
// block-number <-> 4x4 position helpers.
package nc_predict_pkg;

  localparam int unsigned TcWidth   = 5;
  localparam int unsigned BlkWidth  = 6;
  localparam int unsigned RowAddrW  = 13;

  localparam logic [BlkWidth-1:0] BaseLuma = 6'd0;
  localparam logic [BlkWidth-1:0] BaseCb   = 6'd18;
  localparam logic [BlkWidth-1:0] BaseCr   = 6'd34;

  typedef enum logic [2:0] {
    StIdle,
    StRdl,
    StRdt,
    StCalc,
    StOut
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [BlkWidth-1:0] base;
    logic [1:0]          x;
    logic [1:0]          y;
  } blk_pos_t;

  // Map a block number to its component base and (x,y) inside the 4x4 grid.
  function automatic blk_pos_t blk_decode(input logic [BlkWidth-1:0] blk);
    blk_pos_t   p;
    logic [3:0] k;
    p.valid = 1'b1;
    p.base  = BaseLuma;
    if (blk <= 6'd15) begin
      p.base = BaseLuma;
    end else if (blk >= 6'd18 && blk <= 6'd33) begin
      p.base = BaseCb;
    end else if (blk >= 6'd34 && blk <= 6'd49) begin
      p.base = BaseCr;
    end else begin
      p.valid = 1'b0;
    end
    k   = 4'(blk - p.base);
    p.x = {k[2], k[0]};
    p.y = {k[3], k[1]};
    return p;
  endfunction

  function automatic logic [3:0] k_of(input logic [1:0] x, input logic [1:0] y);
    return {y[1], x[1], y[0], x[0]};
  endfunction

endpackage

// File: rtl/nc_predict_if.sv
// Request/result and TotalCoeff write-back signals of the nC predictor.
interface nc_predict_if;
  import nc_predict_pkg::*;

  logic                nC_start;
  logic [BlkWidth-1:0] nC_blk_num;
  logic [7:0]          mb_num_h;
  logic [7:0]          mb_num_v;
  logic                TC_wr_n;
  logic [BlkWidth-1:0] TC_A_wr_addr;
  logic [RowAddrW-1:0] TC_B_wr_addr;
  logic [TcWidth-1:0]  TC_din;
  logic [TcWidth-1:0]  nC;
  logic                nC_valid;
  logic                nC_busy;

  modport master (
    output nC_start, nC_blk_num, mb_num_h, mb_num_v,
    output TC_wr_n, TC_A_wr_addr, TC_B_wr_addr, TC_din,
    input  nC, nC_valid, nC_busy
  );

  modport slave (
    input  nC_start, nC_blk_num, mb_num_h, mb_num_v,
    input  TC_wr_n, TC_A_wr_addr, TC_B_wr_addr, TC_din,
    output nC, nC_valid, nC_busy
  );

endinterface

// File: rtl/tc_b_ram.sv
// Row TotalCoeff store: simple dual-port RAM, one write port and one
// registered read port; a colliding read returns the pre-write contents.
module tc_b_ram #(
  parameter int unsigned AddrWidth = 13,
  parameter int unsigned Width     = 5
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [AddrWidth-1:0] i_waddr,
  input  logic [Width-1:0]     i_wdata,
  input  logic [AddrWidth-1:0] i_raddr,
  output logic [Width-1:0]     o_rdata
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/nc_predict.sv
// CAVLC nC predictor: averages the TotalCoeff of the left and top neighbour
// blocks, fetched from the current-MB array (TC_A) or the row RAM (TC_B).
module nc_predict
  import nc_predict_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  nc_predict_if.slave  bus
);

  state_e r_state;
  state_e w_state_next;

  logic [TcWidth-1:0]  r_tc_a [64];
  logic [BlkWidth-1:0] r_blk;
  logic [7:0]          r_h;
  logic [7:0]          r_v;
  logic [TcWidth-1:0]  r_na;
  logic [TcWidth-1:0]  r_nc;

  logic                w_we;
  blk_pos_t            w_pos;
  logic                w_left_int;
  logic                w_top_int;
  logic                w_left_avail;
  logic                w_top_avail;
  logic [BlkWidth-1:0] w_left_a_addr;
  logic [BlkWidth-1:0] w_top_a_addr;
  logic [RowAddrW-1:0] w_left_b_addr;
  logic [RowAddrW-1:0] w_top_b_addr;
  logic [RowAddrW-1:0] w_rd_addr;
  logic [TcWidth-1:0]  w_ram_rdata;
  logic [TcWidth-1:0]  w_na;
  logic [TcWidth-1:0]  w_nb;
  logic [5:0]          w_sum;
  logic [TcWidth-1:0]  w_nc;
  logic                w_valid;
  logic                w_busy;

  // Write-back updates both stores together; suppressed during reset.
  assign w_we = ~bus.TC_wr_n & ~reset;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_tc_a[bus.TC_A_wr_addr] <= bus.TC_din;
    end
  end

  tc_b_ram #(
    .AddrWidth (RowAddrW),
    .Width     (TcWidth)
  ) u_tc_b_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (bus.TC_B_wr_addr),
    .i_wdata (bus.TC_din),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_rdata)
  );

  // Neighbour addressing, derived from the request fields latched at start.
  assign w_pos         = blk_decode(r_blk);
  assign w_left_int    = (w_pos.x != 2'd0);
  assign w_top_int     = (w_pos.y != 2'd0);
  assign w_left_a_addr = w_pos.base + {2'b00, k_of(w_pos.x - 2'd1, w_pos.y)};
  assign w_top_a_addr  = w_pos.base + {2'b00, k_of(w_pos.x, w_pos.y - 2'd1)};
  assign w_left_b_addr = {r_h[6:0] - 7'd1, w_pos.base + {2'b00, k_of(2'd3, w_pos.y)}};
  assign w_top_b_addr  = {r_h[6:0], w_pos.base + {2'b00, k_of(w_pos.x, 2'd3)}};
  assign w_left_avail  = w_pos.valid & (w_left_int | (r_h != 8'd0));
  assign w_top_avail   = w_pos.valid & (w_top_int | (r_v != 8'd0));

  assign w_rd_addr = (r_state == StRdl) ? w_left_b_addr : w_top_b_addr;

  assign w_na  = w_left_int ? r_tc_a[w_left_a_addr] : w_ram_rdata;
  assign w_nb  = w_top_int ? r_tc_a[w_top_a_addr] : w_ram_rdata;
  assign w_sum = {1'b0, r_na} + {1'b0, w_nb} + 6'd1;

  always_comb begin
    w_nc = '0;
    unique case ({w_left_avail, w_top_avail})
      2'b11:   w_nc = w_sum[5:1];
      2'b10:   w_nc = r_na;
      2'b01:   w_nc = w_nb;
      default: w_nc = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_valid      = 1'b0;
    w_busy       = 1'b1;
    unique case (r_state)
      StIdle: begin
        w_busy = 1'b0;
        if (bus.nC_start) begin
          w_state_next = StRdl;
        end
      end
      StRdl:  w_state_next = StRdt;
      StRdt:  w_state_next = StCalc;
      StCalc: w_state_next = StOut;
      StOut: begin
        w_valid      = 1'b1;
        w_state_next = StIdle;
      end
      default: begin
        w_busy       = 1'b0;
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == StIdle && bus.nC_start) begin
      r_blk <= bus.nC_blk_num;
      r_h   <= bus.mb_num_h;
      r_v   <= bus.mb_num_v;
    end
    if (r_state == StRdt) begin
      r_na <= w_na;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_nc <= '0;
    end else if (r_state == StCalc) begin
      r_nc <= w_nc;
    end
  end

  assign bus.nC       = r_nc;
  assign bus.nC_valid = w_valid;
  assign bus.nC_busy  = w_busy;

endmodule

// File: tb/tb_nc_predict.sv
// Self-checking bench for nc_predict: table-driven requests plus hand-written
// sequences, with a queue of expected results checked as nC_valid appears.
module tb_nc_predict;

  logic clk;
  logic reset;

  nc_predict_if bus ();

  nc_predict dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0] nc;
    int         due;
  } exp_t;

  typedef struct {
    logic [7:0] h;
    logic [7:0] v;
    logic [5:0] blk;
    logic [4:0] nc;
  } vec_t;

  localparam logic [12:0] JunkB = 13'h1FFF;
  localparam logic [5:0]  JunkA = 6'd63;

  exp_t q[$];
  vec_t vecs[12];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [12:0] b, input logic [4:0] d);
    bus.TC_wr_n      = 1'b0;
    bus.TC_A_wr_addr = a;
    bus.TC_B_wr_addr = b;
    bus.TC_din       = d;
    tick();
    bus.TC_wr_n = 1'b1;
  endtask

  // Drives a start pulse this cycle; expected result due 4 cycles later.
  task automatic launch(input logic [7:0] h, input logic [7:0] v, input logic [5:0] blk,
                        input logic [4:0] nc, input bit expect_it);
    exp_t e;
    bus.mb_num_h   = h;
    bus.mb_num_v   = v;
    bus.nC_blk_num = blk;
    bus.nC_start   = 1'b1;
    if (expect_it) begin
      e.nc  = nc;
      e.due = cyc + 4;
      q.push_back(e);
    end
    tick();
    bus.nC_start = 1'b0;
  endtask

  task automatic req(input logic [7:0] h, input logic [7:0] v, input logic [5:0] blk,
                     input logic [4:0] nc);
    launch(h, v, blk, nc, 1'b1);
    repeat (4) tick();
  endtask

  // Scoreboard: compare value and latency on each strobe, flag missing ones.
  always @(negedge clk) begin
    exp_t e;
    if (bus.nC_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        check("nc_value", int'(bus.nC), int'(e.nc));
        check("latency", cyc, e.due);
      end
    end else if (q.size() > 0 && cyc > q[0].due) begin
      e = q.pop_front();
      check("missing_valid", 0, 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'd0, 8'd0, 6'd37, 5'd2};
    vecs[1]  = '{8'd0, 8'd0, 6'd49, 5'd14};
    vecs[2]  = '{8'd0, 8'd0, 6'd40, 5'd4};
    vecs[3]  = '{8'd0, 8'd0, 6'd43, 5'd6};
    vecs[4]  = '{8'd0, 8'd0, 6'd46, 5'd8};
    vecs[5]  = '{8'd0, 8'd0, 6'd38, 5'd1};
    vecs[6]  = '{8'd0, 8'd0, 6'd42, 5'd2};
    vecs[7]  = '{8'd4, 8'd4, 6'd16, 5'd0};
    vecs[8]  = '{8'd4, 8'd4, 6'd17, 5'd0};
    vecs[9]  = '{8'd4, 8'd4, 6'd50, 5'd0};
    vecs[10] = '{8'd4, 8'd4, 6'd63, 5'd0};
    vecs[11] = '{8'd0, 8'd0, 6'd21, 5'd16};

    reset            = 1'b1;
    bus.nC_start     = 1'b0;
    bus.nC_blk_num   = '0;
    bus.mb_num_h     = '0;
    bus.mb_num_v     = '0;
    bus.TC_wr_n      = 1'b1;
    bus.TC_A_wr_addr = '0;
    bus.TC_B_wr_addr = '0;
    bus.TC_din       = '0;
    tick();
    tick();
    check("reset_nc", int'(bus.nC), 0);
    check("reset_valid", int'(bus.nC_valid), 0);
    check("reset_busy", int'(bus.nC_busy), 0);
    reset = 1'b0;
    tick();

    // Corner MB: no neighbours at all.
    req(8'd0, 8'd0, 6'd0, 5'd0);

    // Both neighbours from the row RAM.
    wr(JunkA, {7'd1, 6'd5}, 5'd7);
    wr(JunkA, {7'd2, 6'd10}, 5'd4);
    req(8'd2, 8'd1, 6'd0, 5'd6);
    repeat (3) tick();
    check("nc_hold", int'(bus.nC), 6);

    // Both neighbours internal.
    wr(6'd0, JunkB, 5'd3);
    wr(6'd1, JunkB, 5'd9);
    wr(6'd2, JunkB, 5'd2);
    req(8'd5, 8'd5, 6'd3, 5'd6);

    // Top only, left unavailable at column 0.
    wr(JunkA, {7'd0, 6'd28}, 5'd16);
    req(8'd0, 8'd3, 6'd18, 5'd16);

    // Table: Cr TC_A[34+i]=i, Cb TC_A[19]=TC_A[20]=16.
    for (int i = 0; i < 16; i++) wr(6'(34 + i), JunkB, 5'(i));
    wr(6'd19, JunkB, 5'd16);
    wr(6'd20, JunkB, 5'd16);
    for (int i = 0; i < 12; i++) req(vecs[i].h, vecs[i].v, vecs[i].blk, vecs[i].nc);

    // Start held for two cycles, then again in OUT: one strobe only.
    launch(8'd0, 8'd0, 6'd0, 5'd0, 1'b1);
    check("busy_rdl", int'(bus.nC_busy), 1);
    bus.nC_start = 1'b1;
    tick();
    bus.nC_start = 1'b0;
    tick();
    tick();
    bus.nC_start = 1'b1;
    tick();
    bus.nC_start = 1'b0;
    check("start_in_out_ignored", int'(bus.nC_busy), 0);
    repeat (6) tick();

    // Reset in CALC drops the request; a write during reset is ignored.
    launch(8'd0, 8'd0, 6'd37, 5'd0, 1'b0);
    tick();
    tick();
    check("busy_calc", int'(bus.nC_busy), 1);
    reset            = 1'b1;
    bus.TC_wr_n      = 1'b0;
    bus.TC_A_wr_addr = 6'd35;
    bus.TC_B_wr_addr = JunkB;
    bus.TC_din       = 5'd13;
    tick();
    reset       = 1'b0;
    bus.TC_wr_n = 1'b1;
    check("reset_drop_valid", int'(bus.nC_valid), 0);
    check("reset_drop_busy", int'(bus.nC_busy), 0);
    repeat (5) tick();
    req(8'd0, 8'd0, 6'd37, 5'd2);

    // TC_A write in CALC to the top neighbour: old value used.
    launch(8'd0, 8'd0, 6'd37, 5'd2, 1'b1);
    tick();
    tick();
    bus.TC_wr_n      = 1'b0;
    bus.TC_A_wr_addr = 6'd35;
    bus.TC_B_wr_addr = JunkB;
    bus.TC_din       = 5'd9;
    tick();
    bus.TC_wr_n = 1'b1;
    repeat (2) tick();
    req(8'd0, 8'd0, 6'd37, 5'd6);

    // TC_B write in RDT to the top address: read-first.
    wr(JunkA, {7'd2, 6'd5}, 5'd3);
    wr(JunkA, {7'd3, 6'd10}, 5'd5);
    launch(8'd3, 8'd1, 6'd0, 5'd4, 1'b1);
    tick();
    bus.TC_wr_n      = 1'b0;
    bus.TC_A_wr_addr = JunkA;
    bus.TC_B_wr_addr = {7'd3, 6'd10};
    bus.TC_din       = 5'd15;
    tick();
    bus.TC_wr_n = 1'b1;
    repeat (3) tick();
    req(8'd3, 8'd1, 6'd0, 5'd9);

    repeat (8) tick();
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
